// File: rtl/mmio_arbiter_pkg.sv
// Shared types for the two-master MMIO arbiter: FSM state encoding and counter width.
package global_types;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  localparam int TXN_CNT_W = 16;

endpackage

// File: rtl/mmio_arbiter_rr_pick2.sv
// Combinational 2-way round-robin select: on a tie the master not granted last wins.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    if (&i_req) o_winner = ~i_last;
    else        o_winner = i_req[1];
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master MMIO arbiter: IDLE -> ACCESS -> RESP, one transaction per 2 cycles sustained.
// Optional bus locking is enabled with the ARB_LOCK_EN macro.
module mmio_arbiter
  import global_types::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_m0_req,
  input  logic                 i_m0_we,
  input  logic [ADDR_W-1:0]    i_m0_addr,
  input  logic [DATA_W-1:0]    i_m0_wd,
  input  logic                 i_m1_req,
  input  logic                 i_m1_we,
  input  logic [ADDR_W-1:0]    i_m1_addr,
  input  logic [DATA_W-1:0]    i_m1_wd,
`ifdef ARB_LOCK_EN
  input  logic                 i_m0_lock,
  input  logic                 i_m1_lock,
`endif
  output logic                 o_m0_gnt,
  output logic                 o_m1_gnt,
  output logic                 o_m0_ack,
  output logic                 o_m1_ack,
  output logic [DATA_W-1:0]    o_m0_rd,
  output logic [DATA_W-1:0]    o_m1_rd,
  output logic                 o_bus_we,
  output logic [ADDR_W-1:0]    o_bus_addr,
  output logic [DATA_W-1:0]    o_bus_wd,
  input  logic [DATA_W-1:0]    i_bus_rd,
  output logic                 o_busy,
  output logic [TXN_CNT_W-1:0] o_txn_count
);

  arb_state_t           r_state;
  logic                 r_last;
  logic                 r_owner;
  logic [1:0]           r_gnt;
  logic [1:0]           r_ack;
  logic [DATA_W-1:0]    r_m0_rd;
  logic [DATA_W-1:0]    r_m1_rd;
  logic                 r_bus_we;
  logic [ADDR_W-1:0]    r_bus_addr;
  logic [DATA_W-1:0]    r_bus_wd;
  logic                 r_busy;
  logic [TXN_CNT_W-1:0] r_txn_count;

  logic [1:0]           w_elig;
  logic                 w_winner;
  logic                 w_valid;

`ifdef ARB_LOCK_EN
  logic w_lock_own;
  // Only the owner's lock counts, and only at the RESP exit edge.
  always_comb begin
    w_lock_own = r_owner ? i_m1_lock : i_m0_lock;
    w_elig     = {i_m1_req, i_m0_req};
    if ((r_state == RESP) && w_lock_own)
      w_elig = r_owner ? {i_m1_req, 1'b0} : {1'b0, i_m0_req};
  end
`else
  always_comb w_elig = {i_m1_req, i_m0_req};
`endif

  rr_pick2 u_pick (
    .i_req    (w_elig),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_gnt       <= 2'b00;
      r_ack       <= 2'b00;
      r_m0_rd     <= '0;
      r_m1_rd     <= '0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wd    <= '0;
      r_busy      <= 1'b0;
      r_txn_count <= '0;
    end else begin
      r_gnt   <= 2'b00;
      r_ack   <= 2'b00;
      r_m0_rd <= '0;
      r_m1_rd <= '0;
      case (r_state)
        IDLE, RESP: begin
          r_bus_we   <= 1'b0;
          r_bus_addr <= '0;
          r_bus_wd   <= '0;
          if (w_valid) begin
            r_state    <= ACCESS;
            r_owner    <= w_winner;
            r_last     <= w_winner;
            r_gnt      <= w_winner ? 2'b10 : 2'b01;
            r_bus_we   <= w_winner ? i_m1_we   : i_m0_we;
            r_bus_addr <= w_winner ? i_m1_addr : i_m0_addr;
            r_bus_wd   <= w_winner ? i_m1_wd   : i_m0_wd;
            r_busy     <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        ACCESS: begin
          r_state     <= RESP;
          r_busy      <= 1'b1;
          r_bus_we    <= 1'b0;
          r_bus_addr  <= '0;
          r_bus_wd    <= '0;
          r_ack       <= r_owner ? 2'b10 : 2'b01;
          r_txn_count <= r_txn_count + TXN_CNT_W'(1);
          if (!r_bus_we) begin
            if (r_owner) r_m1_rd <= i_bus_rd;
            else         r_m0_rd <= i_bus_rd;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_m0_gnt    = r_gnt[0];
  assign o_m1_gnt    = r_gnt[1];
  assign o_m0_ack    = r_ack[0];
  assign o_m1_ack    = r_ack[1];
  assign o_m0_rd     = r_m0_rd;
  assign o_m1_rd     = r_m1_rd;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wd    = r_bus_wd;
  assign o_busy      = r_busy;
  assign o_txn_count = r_txn_count;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: directed vector table, corner sequences, randomized masters vs a timeline model.
module tb_mmio_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m_req [2];
  logic        m_we  [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd  [2];
`ifdef ARB_LOCK_EN
  logic        m_lock[2];
`endif
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack;
  logic [31:0] m0_rd, m1_rd;
  logic        bus_we;
  logic [31:0] bus_addr, bus_wd, bus_rd;
  logic        busy;
  logic [15:0] txn_count;

  int n_chk = 0;
  int n_err = 0;

  mmio_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_m0_req    (m_req[0]),
    .i_m0_we     (m_we[0]),
    .i_m0_addr   (m_addr[0]),
    .i_m0_wd     (m_wd[0]),
    .i_m1_req    (m_req[1]),
    .i_m1_we     (m_we[1]),
    .i_m1_addr   (m_addr[1]),
    .i_m1_wd     (m_wd[1]),
`ifdef ARB_LOCK_EN
    .i_m0_lock   (m_lock[0]),
    .i_m1_lock   (m_lock[1]),
`endif
    .o_m0_gnt    (m0_gnt),
    .o_m1_gnt    (m1_gnt),
    .o_m0_ack    (m0_ack),
    .o_m1_ack    (m1_ack),
    .o_m0_rd     (m0_rd),
    .o_m1_rd     (m1_rd),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_wd    (bus_wd),
    .i_bus_rd    (bus_rd),
    .o_busy      (busy),
    .o_txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave mux stand-in: read data is a fixed function of the address on the bus.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h804) return 32'h78;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always_comb bus_rd = rd_fn(bus_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic zero_inputs();
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_wd[i] = 0;
`ifdef ARB_LOCK_EN
      m_lock[i] = 0;
`endif
    end
  endtask

  // Leaves the bench at posedge+1 with one idle edge already taken after release.
  task automatic do_reset();
    zero_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r0, w0; logic [31:0] a0, d0;
    logic        r1, w1; logic [31:0] a1, d1;
    logic        g0, g1, k0, k1, bwe;
    logic [31:0] baddr, bwd, rd0, rd1;
    logic        bsy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[19];

  task automatic run_table();
    logic [31:0] d0;
    d0 = 32'hDEAD_0001;
    tv[0]  = '{1,0,'h804,d0, 0,0,0,0,        0,0,0,0,0, 0,0,'x,'x, 0,0};
    tv[1]  = '{1,0,'h804,d0, 0,0,0,0,        1,0,0,0,0, 'h804,d0,'x,0, 1,0};
    tv[2]  = '{0,0,0,0,      1,1,'h904,'h10, 0,0,1,0,0, 'x,'x,'h78,0, 1,1};
    tv[3]  = '{0,0,0,0,      1,1,'h904,'h10, 0,1,0,0,1, 'h904,'h10,0,'x, 1,1};
    tv[4]  = '{0,0,0,0,      0,0,0,0,        0,0,0,1,0, 'x,'x,0,'x, 1,2};
    tv[5]  = '{1,0,'h100,0,  1,0,'h200,0,    0,0,0,0,0, 0,0,'x,'x, 0,2};
    tv[6]  = '{1,0,'h100,0,  1,0,'h200,0,    1,0,0,0,0, 'h100,0,'x,0, 1,2};
    tv[7]  = '{1,0,'h104,0,  1,0,'h200,0,    0,0,1,0,0, 'x,'x,rd_fn('h100),0, 1,3};
    tv[8]  = '{1,0,'h104,0,  1,0,'h200,0,    0,1,0,0,0, 'h200,0,0,'x, 1,3};
    tv[9]  = '{1,0,'h104,0,  1,0,'h204,0,    0,0,0,1,0, 'x,'x,0,rd_fn('h200), 1,4};
    tv[10] = '{1,0,'h104,0,  1,0,'h204,0,    1,0,0,0,0, 'h104,0,'x,0, 1,4};
    tv[11] = '{0,0,0,0,      1,0,'h204,0,    0,0,1,0,0, 'x,'x,rd_fn('h104),0, 1,5};
    tv[12] = '{0,0,0,0,      1,0,'h204,0,    0,1,0,0,0, 'h204,0,0,'x, 1,5};
    tv[13] = '{0,0,0,0,      0,0,0,0,        0,0,0,1,0, 'x,'x,0,rd_fn('h204), 1,6};
    tv[14] = '{0,0,0,0,      0,0,0,0,        0,0,0,0,0, 0,0,'x,'x, 0,6};
    tv[15] = '{0,0,0,0,      1,0,'h300,0,    0,0,0,0,0, 0,0,'x,'x, 0,6};
    tv[16] = '{0,0,0,0,      1,0,'h300,0,    0,1,0,0,0, 'h300,0,0,'x, 1,6};
    tv[17] = '{0,0,0,0,      0,0,0,0,        0,0,0,1,0, 'x,'x,0,rd_fn('h300), 1,7};
    tv[18] = '{0,0,0,0,      0,0,0,0,        0,0,0,0,0, 0,0,'x,'x, 0,7};
    for (int i = 0; i < 19; i++) begin
      m_req[0] = tv[i].r0; m_we[0] = tv[i].w0; m_addr[0] = tv[i].a0; m_wd[0] = tv[i].d0;
      m_req[1] = tv[i].r1; m_we[1] = tv[i].w1; m_addr[1] = tv[i].a1; m_wd[1] = tv[i].d1;
      @(negedge clk);
      chk($sformatf("tv%0d m0_gnt", i), m0_gnt, tv[i].g0);
      chk($sformatf("tv%0d m1_gnt", i), m1_gnt, tv[i].g1);
      chk($sformatf("tv%0d m0_ack", i), m0_ack, tv[i].k0);
      chk($sformatf("tv%0d m1_ack", i), m1_ack, tv[i].k1);
      chk($sformatf("tv%0d bus_we", i), bus_we, tv[i].bwe);
      chk($sformatf("tv%0d busy", i), busy, tv[i].bsy);
      chk($sformatf("tv%0d txn_count", i), txn_count, tv[i].cnt);
      if (!$isunknown(tv[i].baddr)) chk($sformatf("tv%0d bus_addr", i), bus_addr, tv[i].baddr);
      if (!$isunknown(tv[i].bwd))   chk($sformatf("tv%0d bus_wd", i), bus_wd, tv[i].bwd);
      if (!$isunknown(tv[i].rd0))   chk($sformatf("tv%0d m0_rd", i), m0_rd, tv[i].rd0);
      if (!$isunknown(tv[i].rd1))   chk($sformatf("tv%0d m1_rd", i), m1_rd, tv[i].rd1);
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- reset during a write ACCESS ----------------
  task automatic reset_midop();
    m_req[0] = 1; m_we[0] = 1; m_addr[0] = 32'hA00; m_wd[0] = 32'h55;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midop bus_we before reset", bus_we, 1);
    m_req[0] = 0;
    #2 rst_n = 0;
    #1;
    chk("midop bus_we async drop", bus_we, 0);
    chk("midop busy async drop", busy, 0);
    chk("midop gnt cleared", m0_gnt, 0);
    chk("midop txn_count cleared", txn_count, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midop no ack", m0_ack, 0);
    rst_n = 1;
    @(posedge clk); #1;
    m_req[0] = 1; m_we[0] = 0; m_addr[0] = 32'h10;
    m_req[1] = 1; m_we[1] = 0; m_addr[1] = 32'h20;
    @(negedge clk);
    chk("midop idle after reset", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midop tie m0_gnt", m0_gnt, 1);
    chk("midop tie m1_gnt", m1_gnt, 0);
    @(posedge clk); #1;
    m_req[0] = 0;
    @(negedge clk);
    chk("midop m0_ack", m0_ack, 1);
    chk("midop count", txn_count, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midop then m1_gnt", m1_gnt, 1);
    @(posedge clk); #1;
    m_req[1] = 0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // ---------------- txn_count wrap ----------------
  task automatic wrap_test();
    force dut.r_txn_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_txn_count;
    @(negedge clk);
    chk("wrap preload", txn_count, 16'hFFFF);
    @(posedge clk); #1;
    m_req[1] = 1; m_we[1] = 0; m_addr[1] = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap gnt", m1_gnt, 1);
    chk("wrap count during access", txn_count, 16'hFFFF);
    @(posedge clk); #1;
    m_req[1] = 0;
    @(negedge clk);
    chk("wrap ack", m1_ack, 1);
    chk("wrap count to zero", txn_count, 16'h0000);
    repeat (2) begin @(posedge clk); #1; end
  endtask

`ifdef ARB_LOCK_EN
  task automatic lock_test();
    int g0n;
    int order[$];
    int exp_order[4];
    logic g0_seen;
    exp_order = '{0, 0, 0, 1};
    g0n = 0;
    g0_seen = 0;
    do_reset();
    m_req[0] = 1; m_addr[0] = 32'h500;
    m_req[1] = 1; m_addr[1] = 32'h600;
    m_lock[0] = 1; m_lock[1] = 1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (g0_seen) begin g0n++; m_addr[0] = m_addr[0] + 4; end
      m_lock[0] = (g0n < 3);
      @(negedge clk);
      if (m0_gnt) order.push_back(0);
      if (m1_gnt) order.push_back(1);
      g0_seen = m0_gnt;
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("lock grant %0d", i), (i < order.size()) ? order[i] : 9, exp_order[i]);
  endtask
`endif

  // ---------------- timeline reference model ----------------
  // A capture at edge c means ACCESS is the cycle after c and RESP the cycle after c+1.
  int          e, cap_e;
  logic        md_last, md_own, md_we;
  logic [31:0] md_addr, md_wd, md_rd;
  logic [15:0] md_cnt;

  task automatic model_reset();
    e = 0; cap_e = -100; md_last = 1; md_own = 0; md_we = 0;
    md_addr = 0; md_wd = 0; md_rd = 0; md_cnt = 0;
  endtask

  task automatic model_edge();
    logic [1:0] elig;
    logic       w;
    if (e == cap_e + 1) begin
      md_rd  = rd_fn(md_addr);
      md_cnt = md_cnt + 1;
    end else begin
      elig = {m_req[1], m_req[0]};
`ifdef ARB_LOCK_EN
      if (e == cap_e + 2 && m_lock[md_own]) elig[~md_own] = 1'b0;
`endif
      if (elig != 2'b00) begin
        w = (elig == 2'b11) ? ~md_last : elig[1];
        md_last = w; md_own = w;
        md_we = m_we[w]; md_addr = m_addr[w]; md_wd = m_wd[w];
        cap_e = e;
      end
    end
  endtask

  task automatic model_check();
    logic acc, rsp;
    logic [31:0] rd_act[2];
    acc = (cap_e == e);
    rsp = (cap_e + 1 == e);
    rd_act[0] = m0_rd; rd_act[1] = m1_rd;
    chk("rnd m0_gnt", m0_gnt, acc && !md_own);
    chk("rnd m1_gnt", m1_gnt, acc && md_own);
    chk("rnd m0_ack", m0_ack, rsp && !md_own);
    chk("rnd m1_ack", m1_ack, rsp && md_own);
    chk("rnd bus_we", bus_we, acc && md_we);
    chk("rnd busy", busy, acc || rsp);
    chk("rnd txn_count", txn_count, md_cnt);
    if (!rsp) begin
      chk("rnd bus_addr", bus_addr, acc ? md_addr : 32'h0);
      chk("rnd bus_wd", bus_wd, acc ? md_wd : 32'h0);
    end
    if (acc || rsp) chk("rnd idle master rd", rd_act[~md_own], 0);
    if (rsp && !md_we) chk("rnd owner rd", rd_act[md_own], md_rd);
  endtask

  task automatic new_txn(input int i);
    m_req[i]  = 1;
    m_we[i]   = 1'($urandom_range(0, 1));
    m_addr[i] = $urandom & 32'hFFFF_FFFC;
    m_wd[i]   = $urandom;
  endtask

  task automatic random_test(input int cycles);
    logic [1:0] g_seen;
    g_seen = 2'b00;
    do_reset();
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < 2; i++) begin
        if (g_seen[i]) begin
          if ($urandom_range(0, 1) == 1) new_txn(i);
          else m_req[i] = 0;
        end else if (!m_req[i] && $urandom_range(0, 2) == 0) begin
          new_txn(i);
        end
`ifdef ARB_LOCK_EN
        m_lock[i] = ($urandom_range(0, 3) == 0);
`endif
      end
      @(negedge clk);
      model_check();
      e++;
      g_seen = {m1_gnt, m0_gnt};
    end
  endtask

  initial begin
    zero_inputs();
    rst_n = 0;
    #2;
    chk("reset m0_gnt", m0_gnt, 0);
    chk("reset m1_ack", m1_ack, 0);
    chk("reset bus_we", bus_we, 0);
    chk("reset bus_addr", bus_addr, 0);
    chk("reset busy", busy, 0);
    chk("reset txn_count", txn_count, 0);
    chk("reset m0_rd", m0_rd, 0);
    do_reset();
    run_table();
    reset_midop();
    wrap_test();
`ifdef ARB_LOCK_EN
    lock_test();
`endif
    random_test(1500);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
